// File: rtl/rom_load_router.sv
// rom_load_router
//   Routes a byte-serial ROM download stream into per-region ROM write strobes.
//   A download session (ioctl_download high) steps the FSM into LOAD. Each rising
//   edge of ioctl_wr seen in LOAD is decoded against the region map. A mapped
//   write produces a one-cycle strobe (rom_we, rom_cs one-hot, region-local
//   rom_addr, rom_data) on the cycle after the edge. An unmapped write sets the
//   sticky addr_error flag.
//
// Optional feature: define ROM_LOAD_CHECKSUM_EN to add the 16-bit checksum port.
//
// Ports
//   clk_49m        in   system clock
//   reset          in   asynchronous, active-low reset
//   ioctl_download in   download session active
//   ioctl_addr     in   loader byte address [ADDR_W]
//   ioctl_data     in   loader byte
//   ioctl_wr       in   write request level (rising edge = event)
//   rom_cs         out  one-hot region select, strobe cycle only
//   rom_we         out  one-cycle write strobe
//   rom_addr       out  region-local address [LOCAL_AW]
//   rom_data       out  registered data byte
//   region_loaded  out  per-region "last byte written" flags
//   load_done      out  session finished (state DONE)
//   addr_error     out  sticky unmapped-write flag
//   checksum       out  modulo-2^16 byte sum of strobed data (ROM_LOAD_CHECKSUM_EN)
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | after reset, waiting for the first download edge
// ST_LOAD | session active, write edges are routed
// ST_DONE | session finished, waiting for a new download edge
module rom_load_router #(
  parameter int NUM_REGIONS = 17,
  parameter int ADDR_W      = 25,
  parameter int LOCAL_AW    = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*5-1:0]      REGION_AW   = '0
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_data,
  input  logic                   ioctl_wr,
  output logic [NUM_REGIONS-1:0] rom_cs,
  output logic                   rom_we,
  output logic [LOCAL_AW-1:0]    rom_addr,
  output logic [7:0]             rom_data,
  output logic [NUM_REGIONS-1:0] region_loaded,
  output logic                   load_done,
  output logic                   addr_error
`ifdef ROM_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t state;

  // primed stays 0 for the first clock after reset so that levels already high
  // at release are captured into the history registers without forming an edge.
  logic primed;
  logic dl_q;
  logic wr_q;

  logic dl_rise;
  logic dl_fall;
  logic wr_rise;

  assign dl_rise = primed &  ioctl_download & ~dl_q;
  assign dl_fall = primed & ~ioctl_download &  dl_q;
  assign wr_rise = primed &  ioctl_wr       & ~wr_q;

  // Per-region decode. The offset is taken at full address width so that the
  // range test cannot wrap, and only its low bits become the local address.
  logic [ADDR_W-1:0]   reg_off   [NUM_REGIONS];
  logic [LOCAL_AW-1:0] reg_local [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] reg_match;
  logic [NUM_REGIONS-1:0] reg_last;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    assign reg_off[g]   = ioctl_addr - REGION_BASE[g*ADDR_W +: ADDR_W];
    assign reg_local[g] = reg_off[g][LOCAL_AW-1:0];
    assign reg_match[g] = (ioctl_addr >= REGION_BASE[g*ADDR_W +: ADDR_W]) &&
                          ((reg_off[g] >> REGION_AW[g*5 +: 5]) == '0);
    assign reg_last[g]  = (reg_off[g] == ((ADDR_ONE << REGION_AW[g*5 +: 5]) - ADDR_ONE));
  end

  // Priority select: scanning downwards lets the lowest matching index win.
  logic [NUM_REGIONS-1:0] hit_sel;
  logic                   hit;
  logic [LOCAL_AW-1:0]    hit_local;
  logic                   hit_last;

  always_comb begin
    hit_sel   = '0;
    hit       = 1'b0;
    hit_local = '0;
    hit_last  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (reg_match[i]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit        = 1'b1;
        hit_local  = reg_local[i];
        hit_last   = reg_last[i];
      end
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      primed        <= 1'b0;
      dl_q          <= 1'b0;
      wr_q          <= 1'b0;
      rom_cs        <= '0;
      rom_we        <= 1'b0;
      rom_addr      <= '0;
      rom_data      <= '0;
      region_loaded <= '0;
      load_done     <= 1'b0;
      addr_error    <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      primed <= 1'b1;
      dl_q   <= ioctl_download;
      wr_q   <= ioctl_wr;
      rom_we <= 1'b0;
      rom_cs <= '0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (dl_rise) begin
            state         <= ST_LOAD;
            load_done     <= 1'b0;
            region_loaded <= '0;
            addr_error    <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
            checksum      <= '0;
`endif
          end
        end

        ST_LOAD: begin
          // A write edge coinciding with the session end is still accepted.
          if (wr_rise) begin
            if (hit) begin
              rom_we   <= 1'b1;
              rom_cs   <= hit_sel;
              rom_addr <= hit_local;
              rom_data <= ioctl_data;
              if (hit_last) begin
                region_loaded <= region_loaded | hit_sel;
              end
`ifdef ROM_LOAD_CHECKSUM_EN
              checksum <= checksum + {8'h00, ioctl_data};
`endif
            end else begin
              addr_error <= 1'b1;
            end
          end
          if (dl_fall) begin
            state     <= ST_DONE;
            load_done <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_router.sv
module tb_rom_load_router;

  localparam int NR = 2;
  localparam int AW = 25;
  localparam int LW = 16;

  logic          clk_49m = 1'b0;
  logic          reset;
  logic          ioctl_download;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic [NR-1:0] rom_cs;
  logic          rom_we;
  logic [LW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [NR-1:0] region_loaded;
  logic          load_done;
  logic          addr_error;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  rom_load_router #(
    .NUM_REGIONS (NR),
    .ADDR_W      (AW),
    .LOCAL_AW    (LW),
    .REGION_BASE ({25'h002000, 25'h000000}),
    .REGION_AW   ({5'd13, 5'd13})
  ) dut (
    .clk_49m        (clk_49m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .rom_cs         (rom_cs),
    .rom_we         (rom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .region_loaded  (region_loaded),
    .load_done      (load_done),
    .addr_error     (addr_error)
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #10 clk_49m = ~clk_49m;

  typedef struct {
    logic          dl;
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [NR-1:0] e_cs;
    logic          e_we;
    logic [LW-1:0] e_addr;
    logic [7:0]    e_data;
    logic [NR-1:0] e_loaded;
    logic          e_done;
    logic          e_err;
    logic [15:0]   e_ck;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rom_cs"},        32'(rom_cs), 0);
    chk({tag, " rom_we"},        32'(rom_we), 0);
    chk({tag, " rom_addr"},      32'(rom_addr), 0);
    chk({tag, " rom_data"},      32'(rom_data), 0);
    chk({tag, " region_loaded"}, 32'(region_loaded), 0);
    chk({tag, " load_done"},     32'(load_done), 0);
    chk({tag, " addr_error"},    32'(addr_error), 0);
`ifdef ROM_LOAD_CHECKSUM_EN
    chk({tag, " checksum"},      32'(checksum), 0);
`endif
  endtask

  initial begin
    //             dl  wr  addr         data    cs    we  raddr     rdata  ld    done err ck
    vec[0]  = '{1'b0, 1'b1, 25'h0005, 8'h00, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vec[1]  = '{1'b1, 1'b0, 25'h0005, 8'h00, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000};
    vec[2]  = '{1'b1, 1'b1, 25'h2003, 8'hA5, 2'b10, 1'b1, 16'h0003, 8'hA5, 2'b00, 1'b0, 1'b0, 16'h00A5};
    vec[3]  = '{1'b1, 1'b0, 25'h2003, 8'hA5, 2'b00, 1'b0, 16'h0003, 8'hA5, 2'b00, 1'b0, 1'b0, 16'h00A5};
    vec[4]  = '{1'b1, 1'b1, 25'h0010, 8'h3C, 2'b01, 1'b1, 16'h0010, 8'h3C, 2'b00, 1'b0, 1'b0, 16'h00E1};
    vec[5]  = '{1'b1, 1'b0, 25'h0010, 8'h3C, 2'b00, 1'b0, 16'h0010, 8'h3C, 2'b00, 1'b0, 1'b0, 16'h00E1};
    vec[6]  = '{1'b1, 1'b1, 25'h1FFF, 8'h11, 2'b01, 1'b1, 16'h1FFF, 8'h11, 2'b01, 1'b0, 1'b0, 16'h00F2};
    vec[7]  = '{1'b1, 1'b0, 25'h1FFF, 8'h11, 2'b00, 1'b0, 16'h1FFF, 8'h11, 2'b01, 1'b0, 1'b0, 16'h00F2};
    vec[8]  = '{1'b1, 1'b1, 25'h4000, 8'h77, 2'b00, 1'b0, 16'h1FFF, 8'h11, 2'b01, 1'b0, 1'b1, 16'h00F2};
    vec[9]  = '{1'b1, 1'b0, 25'h4000, 8'h77, 2'b00, 1'b0, 16'h1FFF, 8'h11, 2'b01, 1'b0, 1'b1, 16'h00F2};
    vec[10] = '{1'b1, 1'b1, 25'h3FFF, 8'h22, 2'b10, 1'b1, 16'h1FFF, 8'h22, 2'b11, 1'b0, 1'b1, 16'h0114};
    vec[11] = '{1'b1, 1'b1, 25'h2005, 8'h33, 2'b00, 1'b0, 16'h1FFF, 8'h22, 2'b11, 1'b0, 1'b1, 16'h0114};
    vec[12] = '{1'b0, 1'b0, 25'h2005, 8'h33, 2'b00, 1'b0, 16'h1FFF, 8'h22, 2'b11, 1'b1, 1'b1, 16'h0114};
    vec[13] = '{1'b0, 1'b1, 25'h2000, 8'h55, 2'b00, 1'b0, 16'h1FFF, 8'h22, 2'b11, 1'b1, 1'b1, 16'h0114};
    vec[14] = '{1'b1, 1'b0, 25'h2000, 8'h55, 2'b00, 1'b0, 16'h1FFF, 8'h22, 2'b00, 1'b0, 1'b0, 16'h0000};
    vec[15] = '{1'b0, 1'b1, 25'h2001, 8'h99, 2'b10, 1'b1, 16'h0001, 8'h99, 2'b00, 1'b1, 1'b0, 16'h0099};
    vec[16] = '{1'b0, 1'b0, 25'h2001, 8'h99, 2'b00, 1'b0, 16'h0001, 8'h99, 2'b00, 1'b1, 1'b0, 16'h0099};

    reset          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    ioctl_wr       = 1'b0;

    step();
    step();
    chk_all_zero("reset");
    reset = 1'b1;

    // Table: inputs are applied, one clock, then outputs are compared.
    for (int v = 0; v < NV; v++) begin
      ioctl_download = vec[v].dl;
      ioctl_wr       = vec[v].wr;
      ioctl_addr     = vec[v].addr;
      ioctl_data     = vec[v].data;
      step();
      chk($sformatf("v%0d rom_cs", v),        32'(rom_cs),        32'(vec[v].e_cs));
      chk($sformatf("v%0d rom_we", v),        32'(rom_we),        32'(vec[v].e_we));
      chk($sformatf("v%0d rom_addr", v),      32'(rom_addr),      32'(vec[v].e_addr));
      chk($sformatf("v%0d rom_data", v),      32'(rom_data),      32'(vec[v].e_data));
      chk($sformatf("v%0d region_loaded", v), 32'(region_loaded), 32'(vec[v].e_loaded));
      chk($sformatf("v%0d load_done", v),     32'(load_done),     32'(vec[v].e_done));
      chk($sformatf("v%0d addr_error", v),    32'(addr_error),    32'(vec[v].e_err));
`ifdef ROM_LOAD_CHECKSUM_EN
      chk($sformatf("v%0d checksum", v),      32'(checksum),      32'(vec[v].e_ck));
`endif
    end

    // Reset in the middle of a session with ioctl_wr held high through release.
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    step();
    chk("mid load_done", 32'(load_done), 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0020;
    ioctl_data = 8'h44;
    step();
    chk("mid rom_we", 32'(rom_we), 1);
    reset = 1'b0;
    #1;
    chk_all_zero("mid-reset");
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("post-release c%0d rom_we", c), 32'(rom_we), 0);
      chk($sformatf("post-release c%0d rom_cs", c), 32'(rom_cs), 0);
      chk($sformatf("post-release c%0d load_done", c), 32'(load_done), 0);
      chk($sformatf("post-release c%0d rom_addr", c), 32'(rom_addr), 0);
    end
    // Write edges while still in IDLE are ignored.
    for (int c = 0; c < 4; c++) begin
      ioctl_wr = (c % 2 == 1);
      step();
      chk($sformatf("idle-edge c%0d rom_we", c), 32'(rom_we), 0);
    end
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h2007;
    ioctl_data = 8'h5A;
    step();
    chk("relaunch rom_we",   32'(rom_we), 1);
    chk("relaunch rom_cs",   32'(rom_cs), 32'h2);
    chk("relaunch rom_addr", 32'(rom_addr), 32'h7);
    chk("relaunch rom_data", 32'(rom_data), 32'h5A);
    ioctl_wr = 1'b0;
    step();

    // Fresh session: 258 writes of 0xFF with ioctl_wr toggling every cycle.
    ioctl_download = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
    for (int i = 0; i < 258; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = AW'(i);
      ioctl_data = 8'hFF;
      step();
      chk($sformatf("burst %0d rom_we", i), 32'(rom_we), 1);
      ioctl_wr = 1'b0;
      step();
    end
    chk("burst rom_addr",      32'(rom_addr), 32'd257);
    chk("burst region_loaded", 32'(region_loaded), 0);
    chk("burst addr_error",    32'(addr_error), 0);
`ifdef ROM_LOAD_CHECKSUM_EN
    chk("burst checksum",      32'(checksum), 32'h00FE);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected completion");
    $fatal(1);
  end

endmodule
